// File: rtl/sd_sektor_schreiber_if.sv
// CPU-side request/response bundle of the SD sector writer.
// The master issues word writes and flush requests; the slave reports completion and busy.
interface sd_sektor_schreiber_if;
    logic [31:0] Adresse;
    logic [31:0] Daten;
    logic        Schreiben;
    logic        Flush;
    logic        Fertig;
    logic        Busy;

    modport master (
        output Adresse, Daten, Schreiben, Flush,
        input  Fertig, Busy
    );

    modport slave (
        input  Adresse, Daten, Schreiben, Flush,
        output Fertig, Busy
    );
endinterface

// File: rtl/sd_sektor_schreiber.sv
// SD sector writer: gathers 32-bit words into a one-sector buffer and streams the dirty
// sector byte-wise (MSB byte of each word first) to an SPI-mode sd_controller core.
// A write to a different sector while the buffer is dirty first flushes the old sector.
module sd_sektor_schreiber #(
    parameter int SEKTOR_WORTE = 128,
    parameter bit BYTE_ADDR    = 1'b1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    sd_sektor_schreiber_if.slave   bus,
    output logic                   sd_wr,
    output logic [7:0]             sd_din,
    input  logic                   sd_ready_for_next_byte,
    input  logic                   sd_ready,
    output logic [31:0]            sd_address
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SPEICHERN = 3'd1,
        FL_WARTE  = 3'd2,
        FL_START  = 3'd3,
        FL_DATEN  = 3'd4,
        FL_ENDE   = 3'd5
    } state_t;

    // Selects byte 'sel' of a word, byte 0 being the most significant one.
    function automatic logic [7:0] byte_sel(input logic [31:0] wort, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = wort[31:24];
            2'd1:    b = wort[23:16];
            2'd2:    b = wort[15:8];
            default: b = wort[7:0];
        endcase
        return b;
    endfunction

    // Card address of a sector: byte address for SDSC cards, block number for SDHC.
    function automatic logic [31:0] sektor_adresse(input logic [24:0] sektor);
        logic [31:0] a;
        if (BYTE_ADDR) begin
            a = {sektor[22:0], 9'd0};
        end else begin
            a = {7'd0, sektor};
        end
        return a;
    endfunction

    logic [31:0] buffer_mem [SEKTOR_WORTE];

    state_t      state_q, state_d;
    logic        dirty_q, dirty_d;
    logic        pending_q, pending_d;
    logic [24:0] sector_q, sector_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        fertig_q, fertig_d;
    logic        sd_wr_q, sd_wr_d;
    logic [7:0]  sd_din_q, sd_din_d;
    logic [31:0] sd_address_q, sd_address_d;
    logic        mem_we_s;
    logic        busy_s;
    logic [8:0]  cnt_next_s;

    assign busy_s     = (state_q != IDLE) | ~sd_ready;
    assign cnt_next_s = cnt_q + 9'd1;

    assign bus.Busy   = busy_s;
    assign bus.Fertig = fertig_q;
    assign sd_wr      = sd_wr_q;
    assign sd_din     = sd_din_q;
    assign sd_address = sd_address_q;

    // Next-state and registered-output logic of the request/flush sequencer.
    always_comb begin
        state_d      = state_q;
        dirty_d      = dirty_q;
        pending_d    = pending_q;
        sector_d     = sector_q;
        cnt_d        = cnt_q;
        fertig_d     = 1'b0;
        sd_wr_d      = 1'b0;
        sd_din_d     = sd_din_q;
        sd_address_d = sd_address_q;
        mem_we_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!busy_s && bus.Schreiben) begin
                    // A write into another sector must first push the dirty one out.
                    if (dirty_q && (bus.Adresse[31:7] != sector_q)) begin
                        state_d   = FL_WARTE;
                        pending_d = 1'b1;
                    end else begin
                        state_d   = SPEICHERN;
                    end
                end else if (!busy_s && bus.Flush) begin
                    if (dirty_q) begin
                        state_d   = FL_WARTE;
                        pending_d = 1'b0;
                    end else begin
                        fertig_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SPEICHERN: begin
                mem_we_s  = 1'b1;
                sector_d  = bus.Adresse[31:7];
                dirty_d   = 1'b1;
                fertig_d  = 1'b1;
                state_d   = IDLE;
            end
            FL_WARTE: begin
                if (sd_ready) begin
                    // Command, address and first byte are presented together.
                    state_d      = FL_START;
                    sd_wr_d      = 1'b1;
                    sd_address_d = sektor_adresse(sector_q);
                    cnt_d        = 9'd0;
                    sd_din_d     = byte_sel(buffer_mem[7'd0], 2'd0);
                end else begin
                    state_d = FL_WARTE;
                end
            end
            FL_START: begin
                state_d = FL_DATEN;
            end
            FL_DATEN: begin
                if (sd_ready_for_next_byte) begin
                    cnt_d    = cnt_next_s;
                    sd_din_d = byte_sel(buffer_mem[cnt_next_s[8:2]], cnt_next_s[1:0]);
                    if (cnt_q == 9'd511) begin
                        state_d = FL_ENDE;
                    end else begin
                        state_d = FL_DATEN;
                    end
                end else begin
                    state_d = FL_DATEN;
                end
            end
            FL_ENDE: begin
                if (sd_ready) begin
                    dirty_d = 1'b0;
                    if (pending_q) begin
                        pending_d = 1'b0;
                        state_d   = SPEICHERN;
                    end else begin
                        fertig_d  = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    state_d = FL_ENDE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers; asynchronous reset aborts any flush in progress.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            dirty_q      <= 1'b0;
            pending_q    <= 1'b0;
            sector_q     <= 25'd0;
            cnt_q        <= 9'd0;
            fertig_q     <= 1'b0;
            sd_wr_q      <= 1'b0;
            sd_din_q     <= 8'd0;
            sd_address_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            dirty_q      <= dirty_d;
            pending_q    <= pending_d;
            sector_q     <= sector_d;
            cnt_q        <= cnt_d;
            fertig_q     <= fertig_d;
            sd_wr_q      <= sd_wr_d;
            sd_din_q     <= sd_din_d;
            sd_address_q <= sd_address_d;
        end
    end

    // Sector buffer RAM; deliberately not cleared by reset.
    always_ff @(posedge Clock) begin
        if (mem_we_s) begin
            buffer_mem[bus.Adresse[6:0]] <= bus.Daten;
        end
    end

endmodule

// File: tb/tb_sd_sektor_schreiber.sv
// Scoreboard bench for sd_sektor_schreiber: stimulus pushes expected SD addresses, bytes
// and completion tags; an SD-core model and a Fertig monitor pop and compare them.
module tb_sd_sektor_schreiber;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        sd_ready = 1'b1;
    logic        rfnb = 1'b0;
    logic        sd_wr, sd_wr0;
    logic [7:0]  sd_din, sd_din0;
    logic [31:0] sd_address, sd_address0;

    sd_sektor_schreiber_if bus ();
    sd_sektor_schreiber_if bus0 ();

    assign bus0.Adresse   = bus.Adresse;
    assign bus0.Daten     = bus.Daten;
    assign bus0.Schreiben = bus.Schreiben;
    assign bus0.Flush     = bus.Flush;

    sd_sektor_schreiber #(.SEKTOR_WORTE(128), .BYTE_ADDR(1'b1)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus),
        .sd_wr(sd_wr), .sd_din(sd_din), .sd_ready_for_next_byte(rfnb),
        .sd_ready(sd_ready), .sd_address(sd_address)
    );

    sd_sektor_schreiber #(.SEKTOR_WORTE(128), .BYTE_ADDR(1'b0)) dut0 (
        .Clock(Clock), .Reset(Reset), .bus(bus0),
        .sd_wr(sd_wr0), .sd_din(sd_din0), .sd_ready_for_next_byte(rfnb),
        .sd_ready(sd_ready), .sd_address(sd_address0)
    );

    always #5 Clock = ~Clock;

    typedef struct { logic [31:0] a1; logic [31:0] a0; } addr_t;
    typedef struct { logic [7:0] v; bit care; } byte_t;

    addr_t exp_addr[$];
    byte_t exp_byte[$];
    int    exp_fertig[$];

    int n_cmp = 0;
    int n_err = 0;
    int wr_count = 0;
    int rfnb_count = 0;
    int exp_wr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not expected / not seen", name);
    endtask

    task automatic push_word(input logic [31:0] w, input bit care);
        byte_t b;
        b.care = care;
        b.v = w[31:24]; exp_byte.push_back(b);
        b.v = w[23:16]; exp_byte.push_back(b);
        b.v = w[15:8];  exp_byte.push_back(b);
        b.v = w[7:0];   exp_byte.push_back(b);
    endtask

    task automatic push_addr(input logic [31:0] a1, input logic [31:0] a0);
        addr_t e;
        e.a1 = a1;
        e.a0 = a0;
        exp_addr.push_back(e);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 4000; n++) begin
            if (!bus.Busy) return;
            @(posedge Clock); #1;
        end
        fail("busy_timeout");
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w, input logic f);
        wait_idle();
        bus.Adresse = a; bus.Daten = d; bus.Schreiben = w; bus.Flush = f;
        @(posedge Clock); #1;
        bus.Schreiben = 1'b0; bus.Flush = 1'b0;
    endtask

    task automatic wait_fertig();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            if (bus.Fertig) begin seen = 1'b1; break; end
            @(posedge Clock); #1;
        end
        if (!seen) fail("fertig_timeout");
        @(posedge Clock); #1;
        @(posedge Clock); #1;
    endtask

    // SD core model: checks address and byte stream of each write command, paces the bytes.
    initial begin : core_model
        addr_t e;
        byte_t b;
        bit    aborted;
        forever begin
            @(posedge Clock); #1;
            if (!Reset && sd_wr) begin
                wr_count++;
                aborted = 1'b0;
                if (exp_addr.size() == 0) begin
                    fail("unexpected_sd_wr");
                end else begin
                    e = exp_addr.pop_front();
                    chk("sd_address", sd_address, e.a1);
                    chk("sd_address_sdhc", sd_address0, e.a0);
                end
                sd_ready = 1'b0;
                for (int i = 0; i < 512; i++) begin
                    @(posedge Clock); #1;
                    if (i == 0) chk("sd_wr_single_cycle", {31'd0, sd_wr}, 32'd0);
                    @(posedge Clock); #1;
                    if (Reset) begin aborted = 1'b1; break; end
                    if (exp_byte.size() == 0) begin
                        fail("byte_underflow");
                    end else begin
                        b = exp_byte.pop_front();
                        if (b.care) chk($sformatf("sd_din[%0d]", i), {24'd0, sd_din}, {24'd0, b.v});
                    end
                    rfnb = 1'b1;
                    @(posedge Clock); #1;
                    rfnb = 1'b0;
                    rfnb_count++;
                end
                if (aborted) exp_byte.delete();
                @(posedge Clock); #1;
                @(posedge Clock); #1;
                sd_ready = 1'b1;
            end
        end
    end

    // Fertig monitor: single-cycle width and number of SD writes seen at completion.
    initial begin : fertig_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge Clock); #1;
            if (bus.Fertig) begin
                chk("fertig_width", {31'd0, prev}, 32'd0);
                if (exp_fertig.size() == 0) fail("unexpected_fertig");
                else chk("fertig_sd_wr_count", wr_count, exp_fertig.pop_front());
            end
            prev = bus.Fertig;
        end
    end

    // Watchdog against a hung run.
    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        bus.Adresse = 32'd0; bus.Daten = 32'd0; bus.Schreiben = 1'b0; bus.Flush = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);

        // Test 1: reset mid-idle, Busy follows ~sd_ready, clean flush completes without traffic
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        chk("rst_sd_wr", {31'd0, sd_wr}, 32'd0);
        chk("rst_fertig", {31'd0, bus.Fertig}, 32'd0);
        chk("rst_sd_din", {24'd0, sd_din}, 32'd0);
        chk("rst_sd_address", sd_address, 32'd0);
        chk("rst_busy_ready1", {31'd0, bus.Busy}, 32'd0);
        sd_ready = 1'b0; #1;
        chk("rst_busy_ready0", {31'd0, bus.Busy}, 32'd1);
        sd_ready = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock); #1;
        exp_fertig.push_back(exp_wr);
        issue(32'd0, 32'd0, 1'b0, 1'b1);
        wait_fertig();

        // Test 2: single word in sector 3, then flush
        exp_fertig.push_back(exp_wr);
        issue(32'h0000_0180, 32'hA1B2C3D4, 1'b1, 1'b0);
        wait_fertig();
        push_addr(32'h0000_0600, 32'h0000_0003);
        push_word(32'hA1B2C3D4, 1'b1);
        for (int i = 1; i < 128; i++) push_word(32'd0, 1'b0);
        exp_wr++;
        exp_fertig.push_back(exp_wr);
        issue(32'd0, 32'd0, 1'b0, 1'b1);
        wait_fertig();

        // Test 3: full sector 1 with word index as data
        for (int i = 0; i < 128; i++) begin
            exp_fertig.push_back(exp_wr);
            issue(32'h80 + i, i, 1'b1, 1'b0);
            wait_fertig();
        end
        push_addr(32'h0000_0200, 32'h0000_0001);
        for (int i = 0; i < 128; i++) push_word(i, 1'b1);
        exp_wr++;
        exp_fertig.push_back(exp_wr);
        issue(32'd0, 32'd0, 1'b0, 1'b1);
        wait_fertig();

        // Test 4: write sector 1 word 5, then sector 2 word 0 forces flush of sector 1
        exp_fertig.push_back(exp_wr);
        issue(32'h0000_0085, 32'hDEADBEEF, 1'b1, 1'b0);
        wait_fertig();
        push_addr(32'h0000_0200, 32'h0000_0001);
        for (int i = 0; i < 128; i++) push_word((i == 5) ? 32'hDEADBEEF : i, 1'b1);
        exp_wr++;
        exp_fertig.push_back(exp_wr);
        issue(32'h0000_0100, 32'h11223344, 1'b1, 1'b0);
        wait_fertig();

        // Test 5: flush of still-dirty sector 2, reset after 100 consumed bytes
        push_addr(32'h0000_0400, 32'h0000_0002);
        for (int i = 0; i < 128; i++)
            push_word((i == 0) ? 32'h11223344 : ((i == 5) ? 32'hDEADBEEF : i), 1'b1);
        exp_wr++;
        base = rfnb_count;
        issue(32'd0, 32'd0, 1'b0, 1'b1);
        for (int n = 0; n < 2000; n++) begin
            if (rfnb_count >= base + 100) break;
            @(negedge Clock);
        end
        chk("rfnb_before_reset", rfnb_count - base, 32'd100);
        Reset = 1'b1;
        repeat (6) @(negedge Clock);
        chk("abort_sd_wr", {31'd0, sd_wr}, 32'd0);
        chk("abort_sd_address", sd_address, 32'd0);
        chk("abort_sd_din", {24'd0, sd_din}, 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        chk("abort_idle_busy", {31'd0, bus.Busy}, 32'd0);
        @(posedge Clock); #1;
        exp_fertig.push_back(exp_wr);
        issue(32'd0, 32'd0, 1'b0, 1'b1);
        wait_fertig();

        // Test 6: Schreiben and Flush together store only; stale words survive reset
        exp_fertig.push_back(exp_wr);
        issue(32'h0000_0180, 32'hA1B2C3D4, 1'b1, 1'b1);
        wait_fertig();
        repeat (5) @(posedge Clock);
        #1;
        push_addr(32'h0000_0600, 32'h0000_0003);
        for (int i = 0; i < 128; i++)
            push_word((i == 0) ? 32'hA1B2C3D4 : ((i == 5) ? 32'hDEADBEEF : i), 1'b1);
        exp_wr++;
        exp_fertig.push_back(exp_wr);
        issue(32'd0, 32'd0, 1'b0, 1'b1);
        wait_fertig();

        wait_idle();
        repeat (10) @(posedge Clock);
        #1;
        chk("left_addr", exp_addr.size(), 32'd0);
        chk("left_bytes", exp_byte.size(), 32'd0);
        chk("left_fertig", exp_fertig.size(), 32'd0);
        chk("total_sd_wr", wr_count, exp_wr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
